inst_rom_ctrl: RTL and testbench

Parametrised, loadable instruction memory for the single-cycle CPU, replacing the fixed hard-coded program table. After reset it accepts a program through a write port in LOAD state. It then switches to RUN and serves instruction fetches from the CPU front end with a registered, one-cycle-latency read and a stall/hold handshake. Out-of-range fetches return a NOP word and flag a fault rather than aliasing.

---
 rtl/inst_rom_ctrl.sv | 178 +++++++++++++++++
 tb/tb_inst_rom_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_ctrl.sv
// -----------------------------------------------------------------------------
// inst_rom_ctrl
//
// Loadable instruction memory for the single-cycle CPU. After reset the block
// sits in LOAD and accepts a program through the write port. prog_done moves it
// to RUN, where it serves instruction fetches with a registered one-cycle read
// and a stall/hold handshake. RUN is terminal until the next reset.
//
// Out-of-range fetches return NOP_WORD and raise fetch_fault. Out-of-range
// writes, and any write attempted in RUN, are dropped and pulse prog_err.
// Address comparisons use the full ADDR_W width, so addresses never alias.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   prog_we      in   program write strobe (honoured in LOAD only)
//   prog_addr    in   program write address            [ADDR_W]
//   prog_data    in   program write data               [INST_W]
//   prog_done    in   end of load, moves LOAD -> RUN
//   fetch_req    in   fetch request from the CPU
//   fetch_addr   in   fetch address (the PC)           [ADDR_W]
//   fetch_stall  in   CPU stall, hold the current result
//   inst_out     out  registered instruction word      [INST_W]
//   fetch_valid  out  inst_out holds a fetch result
//   fetch_fault  out  current result came from an out-of-range address
//   prog_err     out  one-cycle pulse for a rejected program write
//   run_mode     out  high in RUN
//
// Every output is driven straight from a flop; there is no combinational
// path from any input to any output.
// -----------------------------------------------------------------------------
module inst_rom_ctrl #(
    parameter int unsigned          INST_W   = 10,
    parameter int unsigned          ADDR_W   = 16,
    parameter int unsigned          DEPTH    = 64,
    parameter logic [INST_W-1:0]    NOP_WORD = {INST_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [INST_W-1:0] prog_data,
    input  logic              prog_done,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_stall,
    output logic [INST_W-1:0] inst_out,
    output logic              fetch_valid,
    output logic              fetch_fault,
    output logic              prog_err,
    output logic              run_mode
);

    // Word-index width; a single-word memory still needs a 1-bit index.
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH may equal 2**ADDR_W, so the limit gets one extra bit.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [INST_W-1:0] mem_q [DEPTH];
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic              perr_q, perr_d;

    logic              prog_in_range;
    logic              fetch_in_range;
    logic [IDX_W-1:0]  prog_idx;
    logic [IDX_W-1:0]  fetch_idx;
    logic              mem_we;

    // Unsigned compare over the full address; upper bits are never dropped.
    assign prog_in_range  = ({1'b0, prog_addr}  < DEPTH_EXT);
    assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_EXT);

    // Low bits are only used as an index once the address is known in range.
    assign prog_idx  = prog_addr[IDX_W-1:0];
    assign fetch_idx = fetch_addr[IDX_W-1:0];

    // A write coinciding with prog_done still lands: state_q is still LOAD.
    assign mem_we = prog_we && prog_in_range && (state_q == ST_LOAD);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_d = state_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        fault_d = fault_q;
        perr_d  = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                // Fetches are ignored while loading.
                valid_d = 1'b0;
                fault_d = 1'b0;
                perr_d  = prog_we && !prog_in_range;
                if (prog_done) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // Memory is frozen; any write attempt is reported.
                perr_d = prog_we;
                if (!fetch_stall) begin
                    if (fetch_req) begin
                        valid_d = 1'b1;
                        fault_d = !fetch_in_range;
                        inst_d  = fetch_in_range ? mem_q[fetch_idx] : NOP_WORD;
                    end else begin
                        // Idle cycle: result retires, the word itself is kept.
                        valid_d = 1'b0;
                        fault_d = 1'b0;
                    end
                end
                // Stalled: everything holds and the request is dropped.
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample their inputs from the same pre-edge values.
        if (!rst_n) begin
            state_q <= ST_LOAD;
            inst_q  <= NOP_WORD;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            perr_q  <= perr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Program storage
    // -------------------------------------------------------------------------
    // NOTE: the memory has an async reset on purpose: the program must be
    // erased on every reset, so it is built from resettable flops rather than
    // an SRAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= NOP_WORD;
            end
        end else if (mem_we) begin
            mem_q[prog_idx] <= prog_data;
        end
    end

    assign inst_out    = inst_q;
    assign fetch_valid = valid_q;
    assign fetch_fault = fault_q;
    assign prog_err    = perr_q;
    assign run_mode    = (state_q == ST_RUN);

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_ctrl
//
// Directed bench for inst_rom_ctrl. Instance u_dut uses the default
// parameters (INST_W=10, ADDR_W=16, DEPTH=64); instance u_small uses
// INST_W=16, ADDR_W=4, DEPTH=1. Inputs change 1 time unit after the rising
// edge and outputs are sampled at the same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_inst_rom_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    // Default-parameter instance
    logic        prog_we;
    logic [15:0] prog_addr;
    logic [9:0]  prog_data;
    logic        prog_done;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_stall;
    logic [9:0]  inst_out;
    logic        fetch_valid;
    logic        fetch_fault;
    logic        prog_err;
    logic        run_mode;

    // Small instance
    logic        s_prog_we;
    logic [3:0]  s_prog_addr;
    logic [15:0] s_prog_data;
    logic        s_prog_done;
    logic        s_fetch_req;
    logic [3:0]  s_fetch_addr;
    logic        s_fetch_stall;
    logic [15:0] s_inst_out;
    logic        s_fetch_valid;
    logic        s_fetch_fault;
    logic        s_prog_err;
    logic        s_run_mode;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_rom_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_done   (prog_done),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_stall (fetch_stall),
        .inst_out    (inst_out),
        .fetch_valid (fetch_valid),
        .fetch_fault (fetch_fault),
        .prog_err    (prog_err),
        .run_mode    (run_mode)
    );

    inst_rom_ctrl #(
        .INST_W (16),
        .ADDR_W (4),
        .DEPTH  (1)
    ) u_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .prog_we     (s_prog_we),
        .prog_addr   (s_prog_addr),
        .prog_data   (s_prog_data),
        .prog_done   (s_prog_done),
        .fetch_req   (s_fetch_req),
        .fetch_addr  (s_fetch_addr),
        .fetch_stall (s_fetch_stall),
        .inst_out    (s_inst_out),
        .fetch_valid (s_fetch_valid),
        .fetch_fault (s_fetch_fault),
        .prog_err    (s_prog_err),
        .run_mode    (s_run_mode)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares all five outputs of the default instance at once.
    task automatic expect_out(input string name, input logic [9:0] e_inst,
                              input logic e_valid, input logic e_fault,
                              input logic e_perr, input logic e_run);
        checks++;
        if ({inst_out, fetch_valid, fetch_fault, prog_err, run_mode} !==
            {e_inst, e_valid, e_fault, e_perr, e_run}) begin
            errors++;
            $display("FAIL %s: got inst=%h valid=%b fault=%b perr=%b run=%b, want inst=%h valid=%b fault=%b perr=%b run=%b",
                     name, inst_out, fetch_valid, fetch_fault, prog_err, run_mode,
                     e_inst, e_valid, e_fault, e_perr, e_run);
        end
    endtask

    task automatic idle_inputs();
        prog_we     = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;
        prog_done   = 1'b0;
        fetch_req   = 1'b0;
        fetch_addr  = '0;
        fetch_stall = 1'b0;
    endtask

    // Reset values are visible while rst_n is low, without any clock edge.
    task automatic test_reset();
        idle_inputs();
        s_prog_we = 1'b0; s_prog_addr = '0; s_prog_data = '0; s_prog_done = 1'b0;
        s_fetch_req = 1'b0; s_fetch_addr = '0; s_fetch_stall = 1'b0;
        rst_n = 1'b0;
        #3;
        expect_out("reset_async", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        expect_out("reset_release", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Load program, with fetches attempted and an out-of-range write.
    task automatic test_load();
        fetch_req  = 1'b1;
        fetch_addr = 16'd0;
        prog_we    = 1'b1;
        prog_addr  = 16'd0;
        prog_data  = 10'b0100000000;
        tick();
        expect_out("load_fetch_ignored0", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        prog_addr  = 16'd1;
        prog_data  = 10'b0010001001;
        tick();
        expect_out("load_fetch_ignored1", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        // Address 64 would alias to 0 if truncated; it must be rejected.
        prog_addr  = 16'd64;
        prog_data  = 10'h3AA;
        tick();
        expect_out("load_oob_perr", 10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        prog_we    = 1'b0;
        tick();
        expect_out("load_perr_single", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        // fetch_req in the prog_done cycle is ignored.
        prog_done  = 1'b1;
        tick();
        expect_out("load_to_run", 10'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        prog_done  = 1'b0;
        fetch_req  = 1'b0;
    endtask

    task automatic test_back_to_back();
        fetch_req  = 1'b1;
        fetch_addr = 16'd0;
        tick();
        expect_out("b2b_addr0", 10'h100, 1'b1, 1'b0, 1'b0, 1'b1);
        fetch_addr = 16'd1;
        tick();
        expect_out("b2b_addr1", 10'h089, 1'b1, 1'b0, 1'b0, 1'b1);
        fetch_req  = 1'b0;
        tick();
        expect_out("idle_hold", 10'h089, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_out_of_range();
        fetch_req  = 1'b1;
        fetch_addr = 16'd64;
        tick();
        expect_out("oob_64", 10'h000, 1'b1, 1'b1, 1'b0, 1'b1);
        fetch_addr = 16'hFFFF;
        tick();
        expect_out("oob_ffff", 10'h000, 1'b1, 1'b1, 1'b0, 1'b1);
        fetch_addr = 16'd63;
        tick();
        expect_out("edge_63", 10'h000, 1'b1, 1'b0, 1'b0, 1'b1);
        fetch_req  = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        fetch_req  = 1'b1;
        fetch_addr = 16'd1;
        tick();
        expect_out("stall_pre", 10'h089, 1'b1, 1'b0, 1'b0, 1'b1);
        fetch_stall = 1'b1;
        fetch_addr  = 16'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("stall_hold%0d", i), 10'h089, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        fetch_stall = 1'b0;
        tick();
        expect_out("stall_release", 10'h100, 1'b1, 1'b0, 1'b0, 1'b1);
        fetch_req  = 1'b0;
        tick();
    endtask

    task automatic test_blocked_write();
        prog_we   = 1'b1;
        prog_addr = 16'd1;
        prog_data = 10'h3FF;
        prog_done = 1'b1;
        tick();
        expect_out("run_write_perr", 10'h100, 1'b0, 1'b0, 1'b1, 1'b1);
        prog_we   = 1'b0;
        prog_done = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 16'd1;
        tick();
        expect_out("run_write_dropped", 10'h089, 1'b1, 1'b0, 1'b0, 1'b1);
        fetch_req  = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous_and_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        expect_out("re_reset", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        prog_we   = 1'b1;
        prog_addr = 16'd2;
        prog_data = 10'h14D;
        prog_done = 1'b1;
        tick();
        expect_out("simul_run", 10'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        prog_we   = 1'b0;
        prog_done = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 16'd2;
        tick();
        expect_out("simul_fetch2", 10'h14D, 1'b1, 1'b0, 1'b0, 1'b1);
        // Earlier program must have been erased by the reset.
        fetch_addr = 16'd0;
        tick();
        expect_out("erased_addr0", 10'h000, 1'b1, 1'b0, 1'b0, 1'b1);
        fetch_addr = 16'd2;
        tick();
        // Reset mid-fetch, between edges.
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("midfetch_reset", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        #2;
        rst_n = 1'b1;
        fetch_req = 1'b0;
        prog_done = 1'b1;
        tick();
        expect_out("bare_done", 10'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        prog_done  = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 16'd2;
        tick();
        expect_out("erased_addr2", 10'h000, 1'b1, 1'b0, 1'b0, 1'b1);
        fetch_req  = 1'b0;
        tick();
    endtask

    task automatic test_param_sweep();
        s_prog_we   = 1'b1;
        s_prog_addr = 4'd0;
        s_prog_data = 16'hBEEF;
        tick();
        // Address 1 is out of range for DEPTH=1.
        s_prog_addr = 4'd1;
        s_prog_data = 16'h1234;
        tick();
        checks++;
        if (s_prog_err !== 1'b1) begin
            errors++;
            $display("FAIL small_oob_perr: got %b want 1", s_prog_err);
        end
        s_prog_we   = 1'b0;
        s_prog_done = 1'b1;
        tick();
        checks++;
        if (s_run_mode !== 1'b1) begin
            errors++;
            $display("FAIL small_run: got %b want 1", s_run_mode);
        end
        s_prog_done  = 1'b0;
        s_fetch_req  = 1'b1;
        s_fetch_addr = 4'd0;
        tick();
        checks++;
        if ({s_inst_out, s_fetch_valid, s_fetch_fault} !== {16'hBEEF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL small_addr0: got inst=%h valid=%b fault=%b want inst=beef valid=1 fault=0",
                     s_inst_out, s_fetch_valid, s_fetch_fault);
        end
        s_fetch_addr = 4'd1;
        tick();
        checks++;
        if ({s_inst_out, s_fetch_valid, s_fetch_fault} !== {16'h0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL small_addr1: got inst=%h valid=%b fault=%b want inst=0000 valid=1 fault=1",
                     s_inst_out, s_fetch_valid, s_fetch_fault);
        end
        s_fetch_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_out_of_range();
        test_stall();
        test_blocked_write();
        test_param_sweep();
        test_simultaneous_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
